sync_fifo_prog: RTL and testbench

- Single-clock, parametrised FIFO. It is the same-domain successor to the dual-clock FIFO, used where producer and consumer share one clock.
- Adds features the dual-clock FIFO lacks:
  - an exact occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags;
  - a selectable first-word-fall-through (FWFT) read mode.
- Sits between on-chip producers and consumers in the same clock domain.

---
 rtl/sync_fifo_prog.sv | 102 ++++++++++
 tb/tb_sync_fifo_prog.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with exact occupancy count, programmable almost flags,
// sticky overflow/underflow errors and optional first-word-fall-through.
module sync_fifo_prog #(
  parameter int DATA_SIZE = 9,
  parameter int ADDR_SIZE = 9,
  parameter bit FWFT      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wData,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rData,
  output logic                 rValid,
  output logic                 wFull,
  output logic                 rEmpty,
  output logic                 wAlmost_full,
  output logic                 rAlmost_empty,
  input  logic [ADDR_SIZE:0]   afull_thresh,
  input  logic [ADDR_SIZE:0]   aempty_thresh,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] CNT_ONE  = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [ADDR_SIZE-1:0] r_wptr;
  logic [ADDR_SIZE-1:0] r_rptr;
  logic [ADDR_SIZE:0]   r_count;
  logic [DATA_SIZE-1:0] r_rdata;
  logic                 r_rvalid;
  logic                 r_ovf;
  logic                 r_udf;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;
  logic [DATA_SIZE-1:0] w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_wr    = winc & ~w_full;
  assign w_rd    = rinc & ~w_empty;
  assign w_head  = r_mem[r_rptr];

  // Storage is never reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd) r_rptr <= r_rptr + PTR_ONE;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_head;
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (winc & w_full) r_ovf <= 1'b1;
      else if (clr_err)  r_ovf <= 1'b0;
      if (rinc & w_empty) r_udf <= 1'b1;
      else if (clr_err)   r_udf <= 1'b0;
    end
  end

  assign rData  = FWFT ? w_head   : r_rdata;
  assign rValid = FWFT ? ~w_empty : r_rvalid;

  assign wFull         = w_full;
  assign rEmpty        = w_empty;
  assign count         = r_count;
  assign overflow      = r_ovf;
  assign underflow     = r_udf;
  assign wAlmost_full  = (r_count >= afull_thresh);
  assign rAlmost_empty = (r_count <= aempty_thresh);

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: standard-read and FWFT instances,
// DEPTH=8, expected values computed by hand or from a small queue model.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst, winc, rinc, clr;
  logic [8:0] wdata;
  logic [3:0] afull, aempty;
  logic [8:0] rdata;
  logic       rvalid, wfull, rempty, afl, ael, ovf, udf;
  logic [3:0] cnt;

  logic       f_rst, f_winc, f_rinc, f_clr;
  logic [8:0] f_wdata;
  logic [8:0] f_rdata;
  logic       f_rvalid, f_wfull, f_rempty, f_afl, f_ael, f_ovf, f_udf;
  logic [3:0] f_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_SIZE(9), .ADDR_SIZE(3), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .winc(winc), .wData(wdata), .rinc(rinc),
    .rData(rdata), .rValid(rvalid), .wFull(wfull), .rEmpty(rempty),
    .wAlmost_full(afl), .rAlmost_empty(ael),
    .afull_thresh(afull), .aempty_thresh(aempty),
    .count(cnt), .overflow(ovf), .underflow(udf), .clr_err(clr)
  );

  sync_fifo_prog #(.DATA_SIZE(9), .ADDR_SIZE(3), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(f_rst), .winc(f_winc), .wData(f_wdata), .rinc(f_rinc),
    .rData(f_rdata), .rValid(f_rvalid), .wFull(f_wfull), .rEmpty(f_rempty),
    .wAlmost_full(f_afl), .rAlmost_empty(f_ael),
    .afull_thresh(4'd6), .aempty_thresh(4'd2),
    .count(f_cnt), .overflow(f_ovf), .underflow(f_udf), .clr_err(f_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [8:0] q[$];
  logic [8:0] exp_d;
  bit         m_wr, m_rd;

  initial begin
    rst = 1'b0; winc = 1'b0; rinc = 1'b0; clr = 1'b0; wdata = '0;
    afull = 4'd0; aempty = 4'd0;
    f_rst = 1'b0; f_winc = 1'b0; f_rinc = 1'b0; f_clr = 1'b0; f_wdata = '0;
    #1;
    chk("rst_count", 32'(cnt), 0);
    chk("rst_empty", 32'(rempty), 1);
    chk("rst_full", 32'(wfull), 0);
    chk("rst_aempty", 32'(ael), 1);
    chk("rst_afull_thr0", 32'(afl), 1);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_udf", 32'(udf), 0);
    afull = 4'd6; aempty = 4'd2;
    tick();
    rst = 1'b1; f_rst = 1'b1;

    // fill, then overflow attempt
    for (int i = 1; i <= 8; i++) begin
      winc = 1'b1; wdata = 9'(i);
      tick();
      chk("fill_count", 32'(cnt), 32'(i));
      chk("fill_full", 32'(wfull), (i == 8) ? 1 : 0);
    end
    wdata = 9'h1FF;
    tick();
    winc = 1'b0;
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(cnt), 8);

    // drain with one-cycle rValid pulses
    for (int i = 1; i <= 8; i++) begin
      rinc = 1'b1;
      tick();
      rinc = 1'b0;
      chk("rd_data", 32'(rdata), 32'(i));
      chk("rd_valid", 32'(rvalid), 1);
      tick();
      chk("rd_valid_drop", 32'(rvalid), 0);
    end
    chk("drain_empty", 32'(rempty), 1);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    chk("udf_set", 32'(udf), 1);
    chk("udf_rdata_hold", 32'(rdata), 9'h008);
    chk("udf_count", 32'(cnt), 0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_udf", 32'(udf), 0);

    // simultaneous on empty: write wins
    winc = 1'b1; rinc = 1'b1; wdata = 9'h055;
    tick();
    winc = 1'b0; rinc = 1'b0;
    chk("sim_e_count", 32'(cnt), 1);
    chk("sim_e_udf", 32'(udf), 1);
    chk("sim_e_rvalid", 32'(rvalid), 0);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    chk("sim_e_data", 32'(rdata), 9'h055);

    // simultaneous on full: read wins
    for (int i = 1; i <= 8; i++) begin
      winc = 1'b1; wdata = 9'(9'h100 + i);
      tick();
    end
    chk("refill_full", 32'(wfull), 1);
    winc = 1'b1; rinc = 1'b1; wdata = 9'h1EE;
    tick();
    winc = 1'b0; rinc = 1'b0;
    chk("sim_f_count", 32'(cnt), 7);
    chk("sim_f_full", 32'(wfull), 0);
    chk("sim_f_ovf", 32'(ovf), 1);
    chk("sim_f_head", 32'(rdata), 9'h101);
    for (int i = 2; i <= 8; i++) begin
      rinc = 1'b1;
      tick();
      chk("sim_f_drain", 32'(rdata), 32'(9'h100 + i));
    end
    rinc = 1'b0;
    chk("sim_f_empty", 32'(rempty), 1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr2_ovf", 32'(ovf), 0);
    chk("clr2_udf", 32'(udf), 0);

    // thresholds 6 / 2
    for (int i = 1; i <= 6; i++) begin
      winc = 1'b1; wdata = 9'(9'h020 + i);
      tick();
      chk("thr_w_afull", 32'(afl), (i >= 6) ? 1 : 0);
      chk("thr_w_aempty", 32'(ael), (i <= 2) ? 1 : 0);
    end
    winc = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rinc = 1'b1;
      tick();
      chk("thr_r_data", 32'(rdata), 32'(9'h020 + i));
      chk("thr_r_afull", 32'(afl), 0);
      chk("thr_r_aempty", 32'(ael), (6 - i <= 2) ? 1 : 0);
    end
    rinc = 1'b0;
    afull = 4'd15; aempty = 4'd9;
    #1;
    chk("thr_big_afull", 32'(afl), 0);
    chk("thr_big_aempty", 32'(ael), 1);
    afull = 4'd6; aempty = 4'd2;
    for (int i = 5; i <= 6; i++) begin
      rinc = 1'b1;
      tick();
      chk("thr_tail", 32'(rdata), 32'(9'h020 + i));
    end
    rinc = 1'b0;

    // interleaved traffic against a queue model, pointers wrap repeatedly
    q.delete();
    for (int k = 0; k < 20; k++) begin
      winc = 1'b1;
      wdata = 9'(k * 37 + 3);
      rinc = (k >= 2);
      m_rd = rinc && (q.size() > 0);
      m_wr = winc && (q.size() < 8);
      exp_d = '0;
      if (m_rd) exp_d = q.pop_front();
      if (m_wr) q.push_back(wdata);
      tick();
      if (m_rd) chk("mix_data", 32'(rdata), 32'(exp_d));
      chk("mix_count", 32'(cnt), 32'(q.size()));
    end
    winc = 1'b0;
    while (q.size() > 0) begin
      rinc = 1'b1;
      exp_d = q.pop_front();
      tick();
      chk("mix_drain", 32'(rdata), 32'(exp_d));
    end
    rinc = 1'b0;
    chk("mix_empty", 32'(rempty), 1);
    chk("mix_no_err", 32'({ovf, udf}), 0);

    // first-word-fall-through
    chk("fw_init_valid", 32'(f_rvalid), 0);
    f_winc = 1'b1; f_wdata = 9'h1A5;
    tick();
    f_winc = 1'b0;
    chk("fw_valid", 32'(f_rvalid), 1);
    chk("fw_data", 32'(f_rdata), 9'h1A5);
    f_rinc = 1'b1;
    tick();
    f_rinc = 1'b0;
    chk("fw_pop_empty", 32'(f_rempty), 1);
    chk("fw_pop_valid", 32'(f_rvalid), 0);
    for (int i = 1; i <= 5; i++) begin
      f_winc = 1'b1; f_wdata = 9'(9'h0F0 + i);
      tick();
    end
    chk("fw_burst_count", 32'(f_cnt), 5);
    chk("fw_burst_head", 32'(f_rdata), 9'h0F1);
    #2;
    f_rst = 1'b0;
    #1;
    chk("fw_arst_count", 32'(f_cnt), 0);
    chk("fw_arst_empty", 32'(f_rempty), 1);
    chk("fw_arst_valid", 32'(f_rvalid), 0);
    f_winc = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
